// File: rtl/fetch_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Shared constants for the fetch/PC stage: FSM state encodings, the default
// reset PC, the MIPS instruction field positions and the controller's
// next-PC select bundle.
// -----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

   // 2-bit state encoding; the spare codes decode as FETCH.
   localparam logic [1:0] ST_FETCH = 2'b00;
   localparam logic [1:0] ST_EXEC  = 2'b01;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Instruction field positions (fixed MIPS encoding).
   localparam int unsigned OPC_MSB  = 31;
   localparam int unsigned OPC_LSB  = 26;
   localparam int unsigned FUNC_MSB = 5;
   localparam int unsigned IMM_MSB  = 15;
   localparam int unsigned TGT_MSB  = 25;

   // Next-PC selects driven by the controller.
   typedef struct packed {
      logic pc_src;
      logic pc_jump;
      logic jump_sel;
   } pc_ctrl_t;

endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_next_pc_calc
// Purely combinational next-PC selection for the fetch stage.
//   i_pc          current PC
//   i_tgt         instruction bits [25:0] (jump target, low 16 = branch imm)
//   i_ctrl        pc_src / pc_jump / jump_sel from the controller
//   i_jr_addr     rs value for JR
//   o_pc_plus4    i_pc + 4 (also the JAL link value)
//   o_next_pc     selected next PC
//   o_jr_misalign JR selected and its target has nonzero low bits
// -----------------------------------------------------------------------------
module fetch_pc_unit_next_pc_calc
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0]  i_pc,
   input  logic [TGT_MSB:0]   i_tgt,
   input  pc_ctrl_t           i_ctrl,
   input  logic [ADDR_W-1:0]  i_jr_addr,
   output logic [ADDR_W-1:0]  o_pc_plus4,
   output logic [ADDR_W-1:0]  o_next_pc,
   output logic               o_jr_misalign
);

   logic [ADDR_W-1:0] w_p4;
   logic [ADDR_W-1:0] w_imm_ext;
   logic [ADDR_W-1:0] w_branch_pc;
   logic [ADDR_W-1:0] w_jump_pc;
   logic [ADDR_W-1:0] w_jr_pc;

   assign w_p4        = i_pc + ADDR_W'(4);
   assign w_imm_ext   = {{(ADDR_W - IMM_MSB - 1){i_tgt[IMM_MSB]}}, i_tgt[IMM_MSB:0]};
   // Modulo-2^ADDR_W add; negative offsets wrap naturally.
   assign w_branch_pc = w_p4 + (w_imm_ext << 2);
   // J/JAL keep the top four bits of the delay-slot PC.
   assign w_jump_pc   = {w_p4[ADDR_W-1:TGT_MSB+3], i_tgt, 2'b00};
   assign w_jr_pc     = {i_jr_addr[ADDR_W-1:2], 2'b00};

   assign o_pc_plus4    = w_p4;
   assign o_jr_misalign = i_ctrl.pc_jump & ~i_ctrl.jump_sel & (|i_jr_addr[1:0]);

   // Jump takes priority over branch.
   always_comb begin
      o_next_pc = w_p4;
      if (i_ctrl.pc_jump) begin
         o_next_pc = i_ctrl.jump_sel ? w_jump_pc : w_jr_pc;
      end else if (i_ctrl.pc_src) begin
         o_next_pc = w_branch_pc;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Instruction-fetch / program-counter stage. Fetches the word at pc_o over a
// variable-latency req/ack handshake, latches it, presents it to the
// controller during EXEC, then commits the next PC chosen by the controller.
//   clk, rst           clock, asynchronous active-high reset
//   imem_req/addr      fetch request and address (address = pc_o)
//   imem_ack/rdata     one-cycle response pulse and instruction word
//   instr_o            latched instruction; opcode/func are its fields
//   instr_valid        high while executing (EXEC)
//   stall              datapath hold; keeps the unit in EXEC
//   pc_src/pc_jump/
//   jump_sel/jr_addr   next-PC controls, sampled only when leaving EXEC
//   pc_o, pc_plus4     current PC and PC+4
//   align_err          sticky flag for a misaligned JR target
// -----------------------------------------------------------------------------
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_o,
   output logic [5:0]         opcode,
   output logic [5:0]         func,
   output logic               instr_valid,
   input  logic               stall,
   input  logic               pc_src,
   input  logic               pc_jump,
   input  logic               jump_sel,
   input  logic [ADDR_W-1:0]  jr_addr,
   output logic [ADDR_W-1:0]  pc_o,
   output logic [ADDR_W-1:0]  pc_plus4,
   output logic               align_err
);

   logic [1:0]         r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_align_err;

   logic               w_in_exec;
   logic               w_commit;
   logic [1:0]         w_state_d;
   logic [ADDR_W-1:0]  w_next_pc;
   logic               w_jr_misalign;
   pc_ctrl_t           w_ctrl;

   // Anything other than EXEC (including spare codes) behaves as FETCH.
   assign w_in_exec = (r_state == ST_EXEC);
   // Control inputs only matter on this edge, so X elsewhere never reaches r_pc.
   assign w_commit  = w_in_exec & ~stall;

   always_comb begin
      w_state_d = ST_FETCH;
      if (w_in_exec) begin
         w_state_d = stall ? ST_EXEC : ST_FETCH;
      end else if (imem_ack) begin
         w_state_d = ST_EXEC;
      end
   end

   assign w_ctrl = '{pc_src: pc_src, pc_jump: pc_jump, jump_sel: jump_sel};

   fetch_pc_unit_next_pc_calc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc_calc (
      .i_pc          (r_pc),
      .i_tgt         (r_instr[TGT_MSB:0]),
      .i_ctrl        (w_ctrl),
      .i_jr_addr     (jr_addr),
      .o_pc_plus4    (pc_plus4),
      .o_next_pc     (w_next_pc),
      .o_jr_misalign (w_jr_misalign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_FETCH;
         r_pc        <= RESET_PC;
         r_instr     <= '0;
         r_align_err <= 1'b0;
      end else begin
         r_state <= w_state_d;
         // Acks seen in EXEC are spurious and dropped.
         if (!w_in_exec && imem_ack) begin
            r_instr <= imem_rdata;
         end
         if (w_commit) begin
            r_pc <= w_next_pc;
            if (w_jr_misalign) begin
               r_align_err <= 1'b1;
            end
         end
      end
   end

   assign imem_req    = ~w_in_exec;
   assign imem_addr   = r_pc;
   assign instr_valid = w_in_exec;
   assign instr_o     = r_instr;
   assign opcode      = r_instr[OPC_MSB:OPC_LSB];
   assign func        = r_instr[FUNC_MSB:0];
   assign pc_o        = r_pc;
   assign align_err   = r_align_err;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Self-checking bench for fetch_pc_unit: directed vector table, a mid-fetch
// reset sequence, then randomized instructions against a reference model.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_o;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        instr_valid;
   logic        stall;
   logic        pc_src;
   logic        pc_jump;
   logic        jump_sel;
   logic [31:0] jr_addr;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4;
   logic        align_err;

   always #5 clk = ~clk;

   fetch_pc_unit #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_o     (instr_o),
      .opcode      (opcode),
      .func        (func),
      .instr_valid (instr_valid),
      .stall       (stall),
      .pc_src      (pc_src),
      .pc_jump     (pc_jump),
      .jump_sel    (jump_sel),
      .jr_addr     (jr_addr),
      .pc_o        (pc_o),
      .pc_plus4    (pc_plus4),
      .align_err   (align_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_pc;
   logic        m_align;

   localparam logic [31:0] I_ADD = 32'h0108_4820;
   localparam logic [31:0] I_JR  = 32'h0100_0008;
   localparam logic [31:0] I_BEQ = 32'h1000_FFFE;
   localparam logic [31:0] I_J40 = 32'h0800_0040;
   localparam logic [31:0] I_J100 = 32'h0800_0100;

   typedef struct {
      logic [31:0] instr;
      int          lat;
      int          stalls;
      logic        src;
      logic        jmp;
      logic        sel;
      logic [31:0] jr;
      logic [31:0] exp_pc;
      logic        exp_align;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference next PC, computed from the architectural rules.
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                            input logic src, input logic jmp, input logic sel,
                                            input logic [31:0] jr);
      logic [31:0] p4;
      logic [15:0] imm;
      logic [25:0] tgt;
      int          off;
      p4 = pc + 32'd4;
      imm = instr[15:0];
      tgt = instr[25:0];
      if (jmp) begin
         if (sel) return (p4 & 32'hF000_0000) + 32'(tgt) * 32'd4;
         return jr - (jr % 32'd4);
      end
      if (src) begin
         off = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
         return p4 + 32'(off * 4);
      end
      return p4;
   endfunction

   task automatic rand_ctrl();
      pc_src   = 1'($urandom);
      pc_jump  = 1'($urandom);
      jump_sel = 1'($urandom);
      jr_addr  = $urandom;
   endtask

   // Entered and left at a negedge with the DUT in FETCH at m_pc.
   task automatic run_instr(input logic [31:0] instr, input int lat, input int stalls,
                            input logic src, input logic jmp, input logic sel,
                            input logic [31:0] jr, input logic [31:0] exp_pc,
                            input logic exp_align);
      for (int k = 1; k <= lat; k++) begin
         check("fetch_req", 32'(imem_req), 32'd1);
         check("fetch_addr", imem_addr, m_pc);
         check("fetch_valid", 32'(instr_valid), 32'd0);
         imem_ack   = (k == lat);
         imem_rdata = (k == lat) ? instr : $urandom;
         stall      = 1'($urandom);
         rand_ctrl();
         @(negedge clk);
      end
      for (int s = 0; s <= stalls; s++) begin
         check("exec_valid", 32'(instr_valid), 32'd1);
         check("exec_req", 32'(imem_req), 32'd0);
         check("exec_instr", instr_o, instr);
         check("exec_opcode", 32'(opcode), 32'(instr[31:26]));
         check("exec_func", 32'(func), 32'(instr[5:0]));
         check("exec_pc", pc_o, m_pc);
         check("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         if (s < stalls) begin
            stall = 1'b1;
            rand_ctrl();
         end else begin
            stall    = 1'b0;
            pc_src   = src;
            pc_jump  = jmp;
            jump_sel = sel;
            jr_addr  = jr;
         end
         @(negedge clk);
      end
      imem_ack = 1'b0;
      check("commit_pc", pc_o, exp_pc);
      check("commit_align", 32'(align_err), 32'(exp_align));
      check("commit_valid", 32'(instr_valid), 32'd0);
      m_pc    = exp_pc;
      m_align = exp_align;
   endtask

   initial begin
      vecs.push_back(vec_t'{I_JR,   2, 0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0});
      vecs.push_back(vec_t'{I_ADD,  1, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         1'b0});
      vecs.push_back(vec_t'{I_ADD,  3, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         1'b0});
      vecs.push_back(vec_t'{I_JR,   1, 0, 1'b0, 1'b1, 1'b0, 32'h20,        32'h20,        1'b0});
      vecs.push_back(vec_t'{I_BEQ,  2, 0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h1C,        1'b0});
      vecs.push_back(vec_t'{I_JR,   1, 0, 1'b0, 1'b1, 1'b0, 32'h20,        32'h20,        1'b0});
      vecs.push_back(vec_t'{I_BEQ,  1, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h24,        1'b0});
      vecs.push_back(vec_t'{I_JR,   1, 0, 1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h1000_0010, 1'b0});
      vecs.push_back(vec_t'{I_J40,  2, 0, 1'b0, 1'b1, 1'b1, 32'h0,         32'h1000_0100, 1'b0});
      vecs.push_back(vec_t'{I_JR,   1, 0, 1'b0, 1'b1, 1'b0, 32'h200,       32'h200,       1'b0});
      vecs.push_back(vec_t'{I_JR,   1, 0, 1'b0, 1'b1, 1'b0, 32'h203,       32'h200,       1'b1});
      vecs.push_back(vec_t'{I_ADD,  2, 0, 1'b0, 1'b0, 1'b0, 32'h3,         32'h204,       1'b1});
      vecs.push_back(vec_t'{I_J100, 1, 4, 1'b1, 1'b1, 1'b1, 32'h0,         32'h400,       1'b1});
      vecs.push_back(vec_t'{I_JR,   1, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1});
      vecs.push_back(vec_t'{I_ADD,  1, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1});

      rst        = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      stall      = 1'b0;
      pc_src     = 1'b0;
      pc_jump    = 1'b0;
      jump_sel   = 1'b0;
      jr_addr    = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_pc", pc_o, 32'h100);
      check("rst_req", 32'(imem_req), 32'd1);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_align", 32'(align_err), 32'd0);
      check("rst_instr", instr_o, 32'h0);
      rst = 1'b0;
      m_pc    = 32'h100;
      m_align = 1'b0;

      foreach (vecs[i]) begin
         run_instr(vecs[i].instr, vecs[i].lat, vecs[i].stalls, vecs[i].src, vecs[i].jmp,
                   vecs[i].sel, vecs[i].jr, vecs[i].exp_pc, vecs[i].exp_align);
      end

      // Reset arriving in the middle of an outstanding fetch.
      imem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_pc", pc_o, 32'h100);
      check("midrst_req", 32'(imem_req), 32'd1);
      check("midrst_valid", 32'(instr_valid), 32'd0);
      check("midrst_align", 32'(align_err), 32'd0);
      check("midrst_instr", instr_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_hold_pc", pc_o, 32'h100);
      m_pc    = 32'h100;
      m_align = 1'b0;

      for (int n = 0; n < 80; n++) begin
         logic [31:0] instr;
         logic [31:0] jr;
         logic        src;
         logic        jmp;
         logic        sel;
         logic [31:0] exp_pc;
         logic        exp_align;
         instr = $urandom;
         jr    = $urandom;
         if ($urandom_range(3) != 0) jr[1:0] = 2'b00;
         src = 1'($urandom);
         jmp = ($urandom_range(2) == 0);
         sel = 1'($urandom);
         exp_pc    = ref_next(m_pc, instr, src, jmp, sel, jr);
         exp_align = m_align | (jmp & ~sel & (jr % 32'd4 != 0));
         run_instr(instr, int'($urandom_range(4, 1)), int'($urandom_range(3)), src, jmp, sel,
                   jr, exp_pc, exp_align);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
